// File: rtl/tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   sched_state_t        : scheduler FSM states
//   DEFAULT_CLKS_PER_BIT : bit period in clocks shared with serial_tx (115200 baud at 100 MHz)
//   UART_FRAME_BITS      : start + 8 data + stop
//   max_int              : elaboration-time helper used to size counters
package tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      GAP    = 2'd3
   } sched_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int UART_FRAME_BITS      = 10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, bit i = requester i wants service
//   ptr       : highest-priority index for this decision
//   grant     : one-hot grant (all zero when req is zero)
//   grant_idx : index of the granted requester (0 when req is zero)
// The search starts at ptr and walks upward with wrap-around; the first set
// request wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one serial_tx byte transmitter between
// NUM_REQ requesters. serial_tx has no done output, so the frame time is
// counted here before the next byte is granted.
//   clk_in        : system clock
//   rst_in        : asynchronous active-low reset
//   req_valid_in  : per-requester byte pending
//   req_data_in   : byte of requester i on [8i+7:8i], stable while valid
//   req_ready_out : one-hot accept pulse, only in IDLE
//   trigger_out   : one-cycle start pulse to serial_tx
//   val_out       : byte to serial_tx, held from grant to next grant
//   busy_out      : high whenever the FSM is not in IDLE
//   grant_id_out  : index of the last granted requester
//   state_out     : current FSM state (debug observation)
//
// Handshake: a byte is transferred on the rising clk_in edge where
// req_valid_in[i] and req_ready_out[i] are both high. Ready is driven
// combinationally in IDLE, only for the arbitration winner, and only when
// that requester's valid is high; a requester may withdraw valid at any time
// before that edge without losing or duplicating a byte.
module uart_tx_scheduler
   import tx_sched_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FRAME_BITS   = UART_FRAME_BITS,
   parameter int GAP_CLKS     = 0
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [NUM_REQ-1:0]           req_valid_in,
   input  logic [8*NUM_REQ-1:0]         req_data_in,
   output logic [NUM_REQ-1:0]           req_ready_out,
   output logic                         trigger_out,
   output logic [7:0]                   val_out,
   output logic                         busy_out,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id_out,
   output sched_state_t                 state_out
);

   localparam int IDX_W      = $clog2(NUM_REQ);
   localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
   localparam int CNT_W      = $clog2(max_int(FRAME_CLKS, GAP_CLKS) + 1);

   localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CLKS - 1);
   // Guarded so a zero gap never produces a negative load constant.
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

   sched_state_t      state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [CNT_W-1:0]  cnt;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic [7:0]         req_byte [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_byte[g] = req_data_in[8*g +: 8];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req       (req_valid_in),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // Gating with rst_in keeps ready low for the whole time reset is held,
   // not just from the next edge.
   always_comb begin
      req_ready_out = '0;
      if (rst_in && state == IDLE) begin
         req_ready_out = arb_grant;
      end
   end

   assign busy_out  = (state != IDLE);
   assign state_out = state;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         cnt          <= '0;
         trigger_out  <= 1'b0;
         val_out      <= 8'h00;
         grant_id_out <= '0;
      end else begin
         trigger_out <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid_in) begin
                  val_out      <= req_byte[arb_idx];
                  grant_id_out <= arb_idx;
                  rr_ptr       <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                  // Registered so the pulse coincides exactly with LAUNCH.
                  trigger_out  <= 1'b1;
                  state        <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt   <= FRAME_LOAD;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (GAP_CLKS > 0) begin
                     cnt   <= GAP_LOAD;
                     state <= GAP;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler.
// Main instance: NUM_REQ=4, CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CLKS=0.
// Second instance with GAP_CLKS=5 for the reset-during-gap scenario.
// The reference model tracks only "cycle when the transmitter becomes free",
// the round-robin pointer and the last granted byte.
module tb_uart_tx_scheduler;
   import tx_sched_pkg::*;

   localparam int N      = 4;
   localparam int CPB    = 4;
   localparam int FB     = 10;
   localparam int GAP_C  = 0;
   localparam int FRAME  = FB * CPB;
   localparam int PERIOD = FRAME + 2 + GAP_C;

   // ---------------- clock / reset ----------------
   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic               rst_in;
   logic [N-1:0]       req_valid;
   logic [8*N-1:0]     req_data;
   logic [N-1:0]       req_ready;
   logic               trigger;
   logic [7:0]         val;
   logic               busy;
   logic [1:0]         gid;
   sched_state_t       state;

   logic               g_rst;
   logic [N-1:0]       g_valid;
   logic [8*N-1:0]     g_data;
   logic [N-1:0]       g_ready;
   logic               g_trig;
   logic [7:0]         g_val;
   logic               g_busy;
   logic [1:0]         g_gid;
   sched_state_t       g_state;

   uart_tx_scheduler #(
      .NUM_REQ(N), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CLKS(GAP_C)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid),
      .req_data_in(req_data), .req_ready_out(req_ready), .trigger_out(trigger),
      .val_out(val), .busy_out(busy), .grant_id_out(gid), .state_out(state)
   );

   uart_tx_scheduler #(
      .NUM_REQ(N), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CLKS(5)
   ) dut_gap (
      .clk_in(clk_in), .rst_in(g_rst), .req_valid_in(g_valid),
      .req_data_in(g_data), .req_ready_out(g_ready), .trigger_out(g_trig),
      .val_out(g_val), .busy_out(g_busy), .grant_id_out(g_gid), .state_out(g_state)
   );

   // ---------------- checking ----------------
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   int         cyc = 0;
   int         free_at = 0;
   int         trig_cyc = -1;
   int         mptr = 0;
   logic [7:0] exp_val = 8'h00;
   int         exp_gid = 0;
   logic [7:0] exp_q[$];

   int obs_ids[$];
   int obs_cycs[$];
   int busy_cnt = 0;
   int trig_cnt = 0;
   bit keep_all = 0;
   bit rand_mode = 0;

   // One clock cycle: inputs are already set; check at negedge, then advance.
   task automatic step();
      int w;
      int idx;
      logic [N-1:0] exp_ready;
      @(negedge clk_in);
      w = -1;
      if (cyc >= free_at && req_valid != '0) begin
         for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
         end
      end
      exp_ready = (w >= 0) ? N'(1 << w) : '0;
      check("ready", req_ready, exp_ready);
      check("trigger", trigger, (cyc == trig_cyc));
      check("busy", busy, (cyc < free_at));
      check("val", val, exp_val);
      check("grant_id", gid, exp_gid);
      if (busy === 1'b1) busy_cnt++;
      if (req_ready != '0) begin
         for (int k = 0; k < N; k++) if (req_ready[k]) obs_ids.push_back(k);
         obs_cycs.push_back(cyc);
      end
      if (trigger === 1'b1) begin
         trig_cnt++;
         if (exp_q.size() == 0) check("sb_extra_trigger", trigger, 0);
         else check("sb_byte", val, exp_q.pop_front());
      end
      if (w >= 0) begin
         exp_q.push_back(req_data[8*w +: 8]);
         exp_val  = req_data[8*w +: 8];
         exp_gid  = w;
         mptr     = (w + 1) % N;
         trig_cyc = cyc + 1;
         free_at  = cyc + PERIOD;
      end
      @(posedge clk_in);
      #1;
      cyc++;
      if (w >= 0) begin
         req_valid[w] = 1'b0;
         if (keep_all) begin
            req_data[8*w +: 8] = 8'($urandom_range(0, 255));
            req_valid[w] = 1'b1;
         end
      end
      if (rand_mode) begin
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k]) begin
               if ($urandom_range(0, 5) == 0) begin
                  req_data[8*k +: 8] = 8'($urandom_range(0, 255));
                  req_valid[k] = 1'b1;
               end
            end else if ($urandom_range(0, 39) == 0) begin
               req_valid[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic clear_obs();
      obs_ids.delete();
      obs_cycs.delete();
      trig_cnt = 0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100 && cyc < free_at; n++) step();
   endtask

   task automatic steps_until_grants(input int want, input int bound);
      for (int n = 0; n < bound && obs_ids.size() < want; n++) step();
      check("grant_count", obs_ids.size(), want);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_trigger"}, trigger, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_val"}, val, 0);
      check({tag, "_gid"}, gid, 0);
      check({tag, "_state"}, state, IDLE);
   endtask

   // Called right after a posedge; holds reset for two cycles.
   task automatic do_reset(input string tag);
      rst_in = 1'b0;
      req_valid = '0;
      #1;
      check_reset_outputs(tag);
      free_at = 0; trig_cyc = -1; mptr = 0; exp_val = 8'h00; exp_gid = 0;
      exp_q.delete();
      repeat (2) @(posedge clk_in);
      #1;
      cyc += 2;
      check_reset_outputs({tag, "_held"});
      rst_in = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_in = 1'b0; g_rst = 1'b0;
      req_valid = '0; req_data = '0;
      g_valid = '0; g_data = '0;
      repeat (2) @(posedge clk_in);
      #1;
      cyc = 2;
      check_reset_outputs("por");
      rst_in = 1'b1; g_rst = 1'b1;

      // Idle after release: no activity for 100 cycles.
      clear_obs();
      repeat (100) step();
      check("idle_triggers", trig_cnt, 0);

      // Single request from requester 2.
      clear_obs(); busy_cnt = 0;
      req_data[23:16] = 8'hA5; req_valid = 4'b0100;
      repeat (45) step();
      check("single_grants", obs_ids.size(), 1);
      if (obs_ids.size() > 0) check("single_id", obs_ids[0], 2);
      check("single_busy_len", busy_cnt, 41);
      check("single_triggers", trig_cnt, 1);
      check("single_val", val, 8'hA5);
      check("single_gid", gid, 2);

      // Reset in the middle of WAIT, then idle for 100 cycles.
      req_data[15:8] = 8'h5A; req_valid = 4'b0010;
      repeat (10) step();
      check("mid_wait_busy", busy, 1);
      do_reset("rst_mid_wait");
      clear_obs();
      repeat (100) step();
      check("post_reset_triggers", trig_cnt, 0);

      // All four valid continuously: rotation 0,1,2,3,0 at PERIOD spacing.
      clear_obs();
      keep_all = 1;
      for (int k = 0; k < N; k++) req_data[8*k +: 8] = 8'($urandom_range(0, 255));
      req_valid = 4'b1111;
      steps_until_grants(5, 400);
      keep_all = 0;
      req_valid = '0;
      step();
      check("rot_triggers", trig_cnt, 5);
      for (int i = 0; i < 5 && i < obs_ids.size(); i++) check("rot_id", obs_ids[i], i % N);
      for (int i = 1; i < 5 && i < obs_cycs.size(); i++)
         check("rot_spacing", obs_cycs[i] - obs_cycs[i-1], PERIOD);
      wait_idle();

      // Fairness after wrap: pointer left at 3 by a grant to requester 2.
      req_data[23:16] = 8'h22; req_valid = 4'b0100;
      step();
      wait_idle();
      clear_obs();
      req_data[7:0] = 8'h10; req_data[31:24] = 8'h33; req_valid = 4'b1001;
      steps_until_grants(2, 200);
      if (obs_ids.size() >= 2) begin
         check("wrap_first", obs_ids[0], 3);
         check("wrap_second", obs_ids[1], 0);
      end
      wait_idle();

      // Late arrival: requester 1 raises valid during WAIT.
      clear_obs();
      req_data[7:0] = 8'h4E; req_valid = 4'b0001;
      repeat (10) step();
      req_data[15:8] = 8'hC3; req_valid[1] = 1'b1;
      steps_until_grants(2, 200);
      if (obs_ids.size() >= 2) begin
         check("late_first", obs_ids[0], 0);
         check("late_second", obs_ids[1], 1);
         check("late_spacing", obs_cycs[1] - obs_cycs[0], PERIOD);
      end
      step();
      check("late_val", val, 8'hC3);
      wait_idle();

      // Randomised traffic with random withdrawals.
      rand_mode = 1;
      repeat (2000) step();
      rand_mode = 0;
      req_valid = '0;
      repeat (50) step();
      check("sb_drained", exp_q.size(), 0);

      // GAP_CLKS=5 instance: reset during GAP, pointer restarts at 0.
      g_data[7:0] = 8'h3C; g_valid = 4'b0001;
      @(negedge clk_in);
      check("g_ready0", g_ready, 4'b0001);
      @(posedge clk_in); #1;             // grant edge G; now in cycle G+1
      g_valid = '0;
      @(negedge clk_in);
      check("g_trigger", g_trig, 1);
      check("g_val0", g_val, 8'h3C);
      repeat (42) @(posedge clk_in);      // now in cycle G+43 (inside GAP)
      #1;
      check("g_busy_in_gap", g_busy, 1);
      check("g_state_gap", g_state, GAP);
      g_rst = 1'b0;
      #1;
      check("g_rst_busy", g_busy, 0);
      check("g_rst_trig", g_trig, 0);
      check("g_rst_val", g_val, 0);
      check("g_rst_gid", g_gid, 0);
      check("g_rst_ready", g_ready, 0);
      check("g_rst_state", g_state, IDLE);
      @(posedge clk_in); #1;
      g_data[7:0] = 8'h11; g_data[15:8] = 8'h77; g_valid = 4'b0011;
      g_rst = 1'b1;
      @(negedge clk_in);
      check("g_ready_after_rst", g_ready, 4'b0001);
      @(posedge clk_in); #1;
      g_valid = '0;
      @(negedge clk_in);
      check("g_gid_after_rst", g_gid, 0);
      check("g_val_after_rst", g_val, 8'h11);
      check("g_trig_after_rst", g_trig, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
